c910_axi_txn_limiter: RTL

C910_AXI_TXN_LIMITER -- requirements
Module: c910_axi_txn_limiter

---
 rtl/c910_pkg.sv | 85 ++++++++
 rtl/c910_txn_counter.sv | 49 ++++
 rtl/c910_axi_txn_limiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/c910_pkg.sv
// ============================================================================
// Module  : c910_pkg
// Brief   : Shared limits, FSM state encoding and AXI4 channel structs for the C910 port limiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package c910_pkg;

  localparam int unsigned NcRead   = 8;
  localparam int unsigned CRead    = 28;
  localparam int unsigned NcWrite  = 8;
  localparam int unsigned CWrite   = 32;
  localparam int unsigned MaxRead  = NcRead + CRead;
  localparam int unsigned MaxWrite = NcWrite + CWrite;

  localparam int unsigned AddrW = 40;
  localparam int unsigned DataW = 128;
  localparam int unsigned IdW   = 8;
  localparam int unsigned UserW = 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } limiter_state_e;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             lock;
    logic [3:0]       cache;
    logic [2:0]       prot;
    logic [3:0]       qos;
    logic [UserW-1:0] user;
  } c910_ax_chan_t;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
    logic [UserW-1:0]   user;
  } c910_w_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [1:0]       resp;
    logic [UserW-1:0] user;
  } c910_b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
    logic [UserW-1:0] user;
  } c910_r_chan_t;

  typedef struct packed {
    c910_ax_chan_t aw;
    logic          aw_valid;
    c910_w_chan_t  w;
    logic          w_valid;
    logic          b_ready;
    c910_ax_chan_t ar;
    logic          ar_valid;
    logic          r_ready;
  } c910_axi_req_t;

  typedef struct packed {
    logic          aw_ready;
    logic          ar_ready;
    logic          w_ready;
    logic          b_valid;
    c910_b_chan_t  b;
    logic          r_valid;
    c910_r_chan_t  r;
  } c910_axi_rsp_t;

endpackage

`default_nettype wire

// File: rtl/c910_txn_counter.sv
// ============================================================================
// Module  : c910_txn_counter
// Brief   : Saturating up/down outstanding-transaction counter with an at-limit flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module c910_txn_counter #(
  parameter int unsigned MAX_COUNT = 36,
  localparam int unsigned CNT_W    = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_max_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CNT_W'(MAX_COUNT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  // Derived from the register only, so a same-cycle retirement never reopens the gate.
  assign at_max_o = (cnt_q == CNT_W'(MAX_COUNT));

`ifndef SYNTHESIS
  a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i) dec_i |-> (cnt_q != '0));
`endif

endmodule

`default_nettype wire

// File: rtl/c910_axi_txn_limiter.sv
// ============================================================================
// Module  : c910_axi_txn_limiter
// Brief   : Caps outstanding AR/AW transactions and supports drain/quiesce.
//           Optional stall statistics when C910_AXI_LIMIT_STATS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module c910_axi_txn_limiter
  import c910_pkg::*;
#(
  parameter int unsigned MaxReadTxns  = MaxRead,
  parameter int unsigned MaxWriteTxns = MaxWrite,
  parameter type         axi_req_t    = c910_axi_req_t,
  parameter type         axi_rsp_t    = c910_axi_rsp_t
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  axi_req_t                            slv_req_i,
  output axi_rsp_t                            slv_rsp_o,
  output axi_req_t                            mst_req_o,
  input  axi_rsp_t                            mst_rsp_i,
  input  logic                                drain_req_i,
  output logic                                drain_ack_o,
  output logic [$clog2(MaxReadTxns+1)-1:0]    rd_cnt_o,
  output logic [$clog2(MaxWriteTxns+1)-1:0]   wr_cnt_o
`ifdef C910_AXI_LIMIT_STATS_EN
  ,
  output logic [31:0]                         rd_stall_cycles_o,
  output logic [31:0]                         wr_stall_cycles_o
`endif
);

  limiter_state_e state_q, state_d;
  logic           drain_ack_q, drain_ack_d;
  logic           rd_at_max, wr_at_max;
  logic           ar_open, aw_open;
  logic           rd_inc, rd_dec, wr_inc, wr_dec;

  assign ar_open = (state_q == ST_RUN) && !rd_at_max;
  assign aw_open = (state_q == ST_RUN) && !wr_at_max;

  // Only the address-channel handshakes are gated; a held valid simply stays pending.
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_open;
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_open;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_open;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_open;
  end

  assign rd_inc = slv_req_i.ar_valid & ar_open & mst_rsp_i.ar_ready;
  assign rd_dec = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;
  assign wr_inc = slv_req_i.aw_valid & aw_open & mst_rsp_i.aw_ready;
  assign wr_dec = mst_rsp_i.b_valid & slv_req_i.b_ready;

  c910_txn_counter #(.MAX_COUNT(MaxReadTxns)) u_rd_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (rd_inc),
    .dec_i    (rd_dec),
    .cnt_o    (rd_cnt_o),
    .at_max_o (rd_at_max)
  );

  c910_txn_counter #(.MAX_COUNT(MaxWriteTxns)) u_wr_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (wr_inc),
    .dec_i    (wr_dec),
    .cnt_o    (wr_cnt_o),
    .at_max_o (wr_at_max)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain_req_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req_i) begin
          state_d = ST_RUN;
        end else if ((rd_cnt_o == '0) && (wr_cnt_o == '0)) begin
          state_d = ST_DRAINED;
        end
      end
      ST_DRAINED: begin
        if (!drain_req_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    drain_ack_d = (state_d == ST_DRAINED);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      drain_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_ack_q <= drain_ack_d;
    end
  end

  assign drain_ack_o = drain_ack_q;

`ifdef C910_AXI_LIMIT_STATS_EN
  logic [31:0] rd_stall_q, rd_stall_d, wr_stall_q, wr_stall_d;

  always_comb begin
    rd_stall_d = rd_stall_q;
    wr_stall_d = wr_stall_q;
    if (slv_req_i.ar_valid && !ar_open && (rd_stall_q != '1)) rd_stall_d = rd_stall_q + 32'd1;
    if (slv_req_i.aw_valid && !aw_open && (wr_stall_q != '1)) wr_stall_d = wr_stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_stall_q <= '0;
      wr_stall_q <= '0;
    end else begin
      rd_stall_q <= rd_stall_d;
      wr_stall_q <= wr_stall_d;
    end
  end

  assign rd_stall_cycles_o = rd_stall_q;
  assign wr_stall_cycles_o = wr_stall_q;
`endif

endmodule

`default_nettype wire
